// File: rtl/mem_responder_if.sv
// CPU <-> memory responder request/response bus (MAR/MDR side of the SLC-3 core).
// Ports: mem_read/mem_write/mem_addr/mem_wdata from CPU; mem_rdata/mem_resp back.
// master = CPU side, slave = responder side.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: serves one CPU request at a time from async SRAM or the I/O word.
// Latency: SRAM request seen in cycle 0 -> mem_resp in cycle WAIT_STATES+2; I/O -> cycle 1.
// Backpressure: CPU holds its request until the one-cycle mem_resp; requests ignored while busy.
// Ports: clk, reset_n (async active-low); mem (slave modport of mem_responder_if);
//        sram_* async SRAM pins; switches in (synchronised), hex_out I/O write register.
module mem_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_responder_if.slave     mem,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_in,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  input  logic [15:0]        switches,
  output logic [15:0]        hex_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic [15:0] rdata_q;
  logic [15:0] hex_q;
  logic [15:0] sw_meta_q;
  logic [15:0] sw_sync_q;

  logic req;
  logic is_io;

  assign req   = mem.mem_read | mem.mem_write;
  assign is_io = (mem.mem_addr == IO_ADDR);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = 4'(WAIT_STATES);
          // I/O word needs no SRAM cycle: answer on the very next cycle.
          state_d = is_io ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Strobes decode straight from state_q so an async reset deasserts them at once.
  always_comb begin
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_dq_oe   = 1'b0;
    mem.mem_resp = 1'b0;
    case (state_q)
      ACCESS: begin
        sram_ce_n = 1'b0;
        if (wr_q) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
        end else begin
          sram_oe_n  = 1'b0;
        end
      end
      RESP:    mem.mem_resp = 1'b1;
      default: ;
    endcase
  end

  // Full-word accesses only: byte lanes simply follow chip enable.
  assign sram_ub_n = sram_ce_n;
  assign sram_lb_n = sram_ce_n;

  // Address and write data stay on the pins after the access ends.
  assign sram_addr   = SRAM_AW'(addr_q);
  assign sram_dq_out = wdata_q;

  // ---------------- switch synchroniser ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q <= 16'd0;
      sw_sync_q <= 16'd0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // ---------------- request latch / data path ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      wr_q    <= 1'b0;
      rdata_q <= 16'd0;
      hex_q   <= 16'd0;
    end else begin
      if (state_q == IDLE && req) begin
        addr_q  <= mem.mem_addr;
        wdata_q <= mem.mem_wdata;
        // Simultaneous read+write resolves to a write.
        wr_q    <= mem.mem_write;
        if (is_io) begin
          if (mem.mem_write) hex_q   <= mem.mem_wdata;
          else               rdata_q <= sw_sync_q;
        end
      end
      // Last access cycle: SRAM data has had the full wait budget to settle.
      if (state_q == ACCESS && cnt_q == 4'd0 && !wr_q) begin
        rdata_q <= sram_dq_in;
      end
    end
  end

  assign mem.mem_rdata = rdata_q;
  assign hex_out       = hex_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: WAIT_STATES=2 instance plus a WAIT_STATES=0 instance.
// Expected results are queued when a request is driven and compared at mem_resp.
// Each instance has its own behavioural async SRAM.
module tb_mem_responder;

  logic clk;
  logic reset_n;
  logic [15:0] switches;
  logic sel;  // 0 = WAIT_STATES=2 instance, 1 = WAIT_STATES=0 instance

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus();
  mem_responder_if bus0();

  logic [19:0] a_addr, b_addr;
  logic [15:0] a_dqi, a_dqo, b_dqi, b_dqo, a_hex, b_hex;
  logic a_oe, a_ce, a_oen, a_we, a_ub, a_lb;
  logic b_oe, b_ce, b_oen, b_we, b_ub, b_lb;

  mem_responder #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF), .SRAM_AW(20)) dut (
    .clk(clk), .reset_n(reset_n), .mem(bus),
    .sram_addr(a_addr), .sram_dq_in(a_dqi), .sram_dq_out(a_dqo), .sram_dq_oe(a_oe),
    .sram_ce_n(a_ce), .sram_oe_n(a_oen), .sram_we_n(a_we), .sram_ub_n(a_ub), .sram_lb_n(a_lb),
    .switches(switches), .hex_out(a_hex)
  );

  mem_responder #(.WAIT_STATES(0), .IO_ADDR(16'hFFFF), .SRAM_AW(20)) dut0 (
    .clk(clk), .reset_n(reset_n), .mem(bus0),
    .sram_addr(b_addr), .sram_dq_in(b_dqi), .sram_dq_out(b_dqo), .sram_dq_oe(b_oe),
    .sram_ce_n(b_ce), .sram_oe_n(b_oen), .sram_we_n(b_we), .sram_ub_n(b_ub), .sram_lb_n(b_lb),
    .switches(switches), .hex_out(b_hex)
  );

  // ---------------- SRAM models ----------------
  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];
  always @(posedge clk) begin
    if (!a_ce && !a_we && a_oe) mem_a[a_addr[9:0]] <= a_dqo;
    if (!b_ce && !b_we && b_oe) mem_b[b_addr[9:0]] <= b_dqo;
  end
  assign a_dqi = (!a_ce && !a_oen) ? mem_a[a_addr[9:0]] : 16'h0000;
  assign b_dqi = (!b_ce && !b_oen) ? mem_b[b_addr[9:0]] : 16'h0000;

  // ---------------- observed signals of the selected instance ----------------
  wire        o_resp  = sel ? bus0.mem_resp  : bus.mem_resp;
  wire [15:0] o_rdata = sel ? bus0.mem_rdata : bus.mem_rdata;
  wire [19:0] o_addr  = sel ? b_addr : a_addr;
  wire [15:0] o_dqo   = sel ? b_dqo  : a_dqo;
  wire        o_dqoe  = sel ? b_oe   : a_oe;
  wire        o_ce    = sel ? b_ce   : a_ce;
  wire        o_oen   = sel ? b_oen  : a_oen;
  wire        o_we    = sel ? b_we   : a_we;
  wire        o_ub    = sel ? b_ub   : a_ub;
  wire        o_lb    = sel ? b_lb   : a_lb;
  wire [15:0] o_hex   = sel ? b_hex  : a_hex;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          lat;
    int          strobes;
    logic        wr;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow [int];
  logic [15:0] exp_rd [2];
  logic [15:0] exp_hex [2];
  logic [15:0] sw_val;

  task automatic drive_req(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    if (sel) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.mem_addr = addr; bus0.mem_wdata = wdata;
    end else begin
      bus.mem_read = rd; bus.mem_write = wr; bus.mem_addr = addr; bus.mem_wdata = wdata;
    end
  endtask

  // Build the expectation for one request and queue it.
  task automatic expect_txn(input string tag, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    exp_t e;
    int   ws  = sel ? 0 : 2;
    int   key = (sel ? 65536 : 0) + int'(addr);
    logic io  = (addr == 16'hFFFF);
    e.tag     = tag;
    e.wr      = wr;
    e.lat     = io ? 1 : ws + 2;
    e.strobes = io ? 0 : ws + 1;
    if (wr) begin
      if (io) exp_hex[sel] = wdata;
      else    shadow[key]  = wdata;
    end else begin
      exp_rd[sel] = io ? sw_val : (shadow.exists(key) ? shadow[key] : 16'h0000);
    end
    e.rdata = exp_rd[sel];
    sb.push_back(e);
  endtask

  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [15:0] addr, input logic [15:0] wdata);
    exp_t e;
    int   wcnt = 0, ocnt = 0, celow = 0, busbad = 0, rc = -1;
    logic got = 1'b0;
    @(posedge clk); #1;
    drive_req(rd, wr, addr, wdata);
    expect_txn(tag, wr, addr, wdata);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (!o_ce) begin
        celow++;
        if (o_addr !== {4'h0, addr}) busbad++;
        if (o_ub !== 1'b0 || o_lb !== 1'b0) busbad++;
      end
      if (!o_we) begin
        wcnt++;
        if (o_dqoe !== 1'b1 || o_dqo !== wdata) busbad++;
      end
      if (!o_oen) begin
        ocnt++;
        if (o_dqoe !== 1'b0) busbad++;
      end
      if (o_resp) begin
        got = 1'b1;
        rc  = c;
        check({tag, "_rdata"}, 32'(o_rdata), 32'(sb[0].rdata));
        drive_req(1'b0, 1'b0, 16'h0000, 16'h0000);
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      drive_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(rc), 32'(e.lat));
    check({tag, "_ce_cycles"}, 32'(celow), 32'(e.strobes));
    check({tag, "_we_cycles"}, 32'(wcnt), 32'(e.wr ? e.strobes : 0));
    check({tag, "_oe_cycles"}, 32'(ocnt), 32'(e.wr ? 0 : e.strobes));
    check({tag, "_bus"}, 32'(busbad), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(o_resp), 32'd0);
    check({tag, "_hex"}, 32'(o_hex), 32'(exp_hex[sel]));
  endtask

  initial begin
    int resp_cnt, t1, t2;
    sel      = 1'b0;
    switches = 16'h0000;
    sw_val   = 16'h0000;
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0; exp_hex[0] = 16'h0; exp_hex[1] = 16'h0;
    bus.mem_read = 0;  bus.mem_write = 0;  bus.mem_addr = 0;  bus.mem_wdata = 0;
    bus0.mem_read = 0; bus0.mem_write = 0; bus0.mem_addr = 0; bus0.mem_wdata = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_resp",  32'(bus.mem_resp), 32'd0);
    check("rst_rdata", 32'(bus.mem_rdata), 32'd0);
    check("rst_hex",   32'(a_hex), 32'd0);
    check("rst_strobes", {27'd0, a_ce, a_oen, a_we, a_ub, a_lb}, 32'h1F);
    check("rst_dqoe",  32'(a_oe), 32'd0);
    check("rst_addr",  32'(a_addr), 32'd0);
    check("rst_dqout", 32'(a_dqo), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // I/O
    txn("io_wr", 1'b0, 1'b1, 16'hFFFF, 16'h1234);
    @(posedge clk); #1;
    switches = 16'h00A5; sw_val = 16'h00A5;
    repeat (3) @(posedge clk);
    txn("io_rd", 1'b1, 1'b0, 16'hFFFF, 16'h0000);

    // SRAM write then read
    txn("sram_wr", 1'b0, 1'b1, 16'h0123, 16'hBEEF);
    txn("sram_rd", 1'b1, 1'b0, 16'h0123, 16'h0000);

    // Read+write collision: write wins, read data untouched
    txn("coll", 1'b1, 1'b1, 16'h0040, 16'h0F0F);
    check("coll_mem", 32'(mem_a[10'h040]), 32'h0F0F);

    // Back-to-back: request held two cycles past mem_resp
    resp_cnt = 0; t1 = -1; t2 = -1;
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 16'h0123, 16'h0000);
    expect_txn("b2b_1", 1'b0, 16'h0123, 16'h0000);
    expect_txn("b2b_2", 1'b0, 16'h0123, 16'h0000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        exp_t e;
        resp_cnt++;
        if (t1 < 0) t1 = c; else t2 = c;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({e.tag, "_rdata"}, 32'(bus.mem_rdata), 32'(e.rdata));
        end else begin
          check("b2b_extra_resp", 32'd1, 32'd0);
        end
      end
      if (c == 7) drive_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    check("b2b_count", 32'(resp_cnt), 32'd2);
    check("b2b_first", 32'(t1), 32'd4);
    check("b2b_gap",   32'(t2 - t1), 32'd5);
    sb.delete();

    // Reset in the middle of an SRAM write
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 16'h0200, 16'h5555);
    @(negedge clk);
    @(negedge clk);
    check("mid_we_active", 32'(a_we), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we",   32'(a_we), 32'd1);
    check("mid_rst_ce",   32'(a_ce), 32'd1);
    check("mid_rst_dqoe", 32'(a_oe), 32'd0);
    check("mid_rst_resp", 32'(bus.mem_resp), 32'd0);
    drive_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0; exp_hex[0] = 16'h0; exp_hex[1] = 16'h0;
    resp_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.mem_resp) resp_cnt++;
    end
    check("post_rst_resp", 32'(resp_cnt), 32'd0);
    check("post_rst_hex",  32'(a_hex), 32'd0);
    check("post_rst_rdata", 32'(bus.mem_rdata), 32'd0);
    // FSM back in IDLE: a fresh read of earlier data completes normally
    txn("post_rst_rd", 1'b1, 1'b0, 16'h0123, 16'h0000);

    // WAIT_STATES=0 instance
    sel = 1'b1;
    @(negedge clk);
    txn("ws0_wr", 1'b0, 1'b1, 16'h0077, 16'hC3C3);
    txn("ws0_rd", 1'b1, 1'b0, 16'h0077, 16'h0000);
    txn("ws0_io_rd", 1'b1, 1'b0, 16'hFFFF, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
